// File: rtl/dct8_pkg.sv
// dct8_pkg: shared constants, state type and
// quantised coefficient generator for the DCT engine.
package dct8_pkg;

   localparam int N     = 8;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_COMPUTE,
      ST_OUTPUT
   } dct8_state_e;

   // cos(m*pi/16) scaled by 2^24, m = 0..8
   function automatic longint cos_q24(input int m);
      longint r;
      case (m)
         0:       r = 64'sd16777216;
         1:       r = 64'sd16454846;
         2:       r = 64'sd15500126;
         3:       r = 64'sd13949745;
         4:       r = 64'sd11863283;
         5:       r = 64'sd9320922;
         6:       r = 64'sd6420363;
         7:       r = 64'sd3273072;
         default: r = 64'sd0;
      endcase
      return r;
   endfunction

   // C[k][n] rounded half away from zero to frac bits
   function automatic int dct8_coef(
      input int k,
      input int n,
      input int frac
   );
      int     m;
      int     sh;
      bit     neg;
      longint v;
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      neg = 1'b0;
      if (m > 8) begin
         m   = 16 - m;
         neg = 1'b1;
      end
      // v = C * 2^25; a(0)*cos(0) equals cos(pi/4)/2
      v  = (k == 0) ? cos_q24(4) : cos_q24(m);
      sh = 25 - frac;
      if (sh > 0)
         v = (v + (64'sd1 <<< (sh - 1))) >>> sh;
      else
         v = v <<< (-sh);
      return neg ? -int'(v) : int'(v);
   endfunction

endpackage

// File: rtl/dct8_coef_rom.sv
// dct8_coef_rom: combinational C[k][n] lookup,
// table built at elaboration from the package function.
module dct8_coef_rom
   import dct8_pkg::*;
#(
   parameter int COEF_FRAC = 12
) (
   input  logic [IDX_W-1:0]            k_i,
   input  logic [IDX_W-1:0]            n_i,
   output logic signed [COEF_FRAC+1:0] coef_o
);

   localparam int CW = COEF_FRAC + 2;

   function automatic logic [N*N*CW-1:0] build_rom();
      logic [N*N*CW-1:0] t;
      int                c;
      t = '0;
      for (int k = 0; k < N; k++) begin
         for (int n = 0; n < N; n++) begin
            c = dct8_coef(k, n, COEF_FRAC);
            t[(k * N + n) * CW +: CW] = c[CW-1:0];
         end
      end
      return t;
   endfunction

   localparam logic [N*N*CW-1:0] ROM = build_rom();

   // row k, column n of the coefficient matrix
   always_comb begin
      coef_o = $signed(ROM[int'({k_i, n_i}) * CW +: CW]);
   end

endmodule

// File: rtl/dct8_stream_engine.sv
// dct8_stream_engine: 8-sample block load, serial
// 64-cycle MAC (forward or inverse DCT), buffered output.
module dct8_stream_engine
   import dct8_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 12,
   parameter int COEF_FRAC = 12
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int CW = COEF_FRAC + 2;
   localparam int PW = IN_W + CW;
   localparam int AW = IN_W + COEF_FRAC + 5;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   localparam logic signed [AW-1:0] HALF =
      {{(AW-COEF_FRAC){1'b0}}, 1'b1,
       {(COEF_FRAC-1){1'b0}}};
   localparam logic signed [AW-1:0] SAT_HI =
      {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_LO =
      {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   dct8_state_e state_q, state_d;

   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] oi_q, oi_d;
   logic [IDX_W-1:0] ii_q, ii_d;
   logic [IDX_W-1:0] oidx_q, oidx_d;
   logic             mode_q, mode_d;

   logic signed [AW-1:0] acc_q, acc_d;

   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;

   logic signed [IN_W-1:0]  xbuf_q [N];
   logic signed [IN_W-1:0]  xbuf_d [N];
   logic signed [OUT_W-1:0] obuf_q [N];
   logic signed [OUT_W-1:0] obuf_d [N];

   logic [IDX_W-1:0]     rom_k;
   logic [IDX_W-1:0]     rom_n;
   logic signed [CW-1:0] coef;

   logic signed [IN_W-1:0]  xv;
   logic signed [PW-1:0]    x_ext;
   logic signed [PW-1:0]    c_ext;
   logic signed [PW-1:0]    prod;
   logic signed [AW-1:0]    prod_ext;
   logic signed [AW-1:0]    sum;
   logic signed [AW-1:0]    rnd;
   logic signed [AW-1:0]    shr;
   logic signed [OUT_W-1:0] res;

   dct8_coef_rom #(
      .COEF_FRAC (COEF_FRAC)
   ) u_rom (
      .k_i    (rom_k),
      .n_i    (rom_n),
      .coef_o (coef)
   );

   // MAC datapath; inverse mode reads the transposed matrix
   always_comb begin
      rom_k    = mode_q ? ii_q : oi_q;
      rom_n    = mode_q ? oi_q : ii_q;
      xv       = xbuf_q[ii_q];
      x_ext    = {{CW{xv[IN_W-1]}}, xv};
      c_ext    = {{IN_W{coef[CW-1]}}, coef};
      prod     = x_ext * c_ext;
      prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
      sum      = acc_q + prod_ext;
      rnd      = sum + HALF;
      shr      = rnd >>> COEF_FRAC;
      if (shr > SAT_HI)
         res = SAT_HI[OUT_W-1:0];
      else if (shr < SAT_LO)
         res = SAT_LO[OUT_W-1:0];
      else
         res = shr[OUT_W-1:0];
   end

   // next-state logic for the LOAD/COMPUTE/OUTPUT sequence
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      oi_d        = oi_q;
      ii_d        = ii_q;
      oidx_d      = oidx_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      xbuf_d      = xbuf_q;
      obuf_d      = obuf_q;
      unique case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               xbuf_d[cnt_q] = in_data;
               if (cnt_q == '0) mode_d = mode;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = ST_COMPUTE;
                  oi_d    = '0;
                  ii_d    = '0;
                  acc_d   = '0;
               end
            end
         end
         ST_COMPUTE: begin
            ii_d = ii_q + 1'b1;
            if (ii_q == LAST) begin
               obuf_d[oi_q] = res;
               acc_d        = '0;
               oi_d         = oi_q + 1'b1;
               if (oi_q == LAST) begin
                  state_d     = ST_OUTPUT;
                  oidx_d      = '0;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b0;
                  out_data_d  = obuf_q[0];
               end
            end else begin
               acc_d = sum;
            end
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               if (oidx_q == LAST) begin
                  state_d     = ST_LOAD;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
               end else begin
                  oidx_d     = oidx_q + 1'b1;
                  out_data_d = obuf_q[oidx_q + 1'b1];
                  out_last_d = (oidx_q + 1'b1) == LAST;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // control and output registers, cleared by clr
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_LOAD;
         cnt_q       <= '0;
         oi_q        <= '0;
         ii_q        <= '0;
         oidx_q      <= '0;
         mode_q      <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         oi_q        <= oi_d;
         ii_q        <= ii_d;
         oidx_q      <= oidx_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // sample and result buffers, fully rewritten each block
   always_ff @(posedge clk) begin
      xbuf_q <= xbuf_d;
      obuf_q <= obuf_d;
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign busy      = (state_q != ST_LOAD);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_dct8_stream_engine.sv
// tb_dct8_stream_engine: scoreboard bench driving three
// engine instances (default, wide input, narrow output).
module tb_dct8_stream_engine;

   localparam real PI = 3.14159265358979323846;

   typedef struct {
      int a;
      int w;
      int s;
      int last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr;
   logic        mode;
   logic        in_valid;
   logic [11:0] in_data;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_last_a, busy_a;
   logic [11:0] out_data_a;
   logic        in_ready_w, out_valid_w, out_last_w, busy_w;
   logic [11:0] out_data_w;
   logic        in_ready_s, out_valid_s, out_last_s, busy_s;
   logic [7:0]  out_data_s;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   bit       bp_en = 1'b0;
   int       bp_i = 0;
   logic [3:0] bp_pat = 4'b1001;

   bit   stall = 1'b0;
   bit   last_seen = 1'b0;
   int   held_d;
   int   held_l;
   exp_t e;

   int x[8];
   int lat;

   dct8_stream_engine u_dut_a (
      .clk(clk), .clr(clr), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data[7:0]),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_data(out_data_a), .out_last(out_last_a),
      .busy(busy_a)
   );

   dct8_stream_engine #(
      .IN_W(12), .OUT_W(12), .COEF_FRAC(12)
   ) u_dut_w (
      .clk(clk), .clr(clr), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data),
      .out_valid(out_valid_w), .out_ready(out_ready),
      .out_data(out_data_w), .out_last(out_last_w),
      .busy(busy_w)
   );

   dct8_stream_engine #(
      .IN_W(8), .OUT_W(8), .COEF_FRAC(12)
   ) u_dut_s (
      .clk(clk), .clr(clr), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data[7:0]),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_last(out_last_s),
      .busy(busy_s)
   );

   task automatic check_eq(
      input string tag, input int got, input int exp
   );
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   function automatic int qcoef(input int k, input int n);
      real a;
      real c;
      a = (k == 0) ? $sqrt(0.125) : 0.5;
      c = a * $cos(real'((2 * n + 1) * k) * PI / 16.0);
      c = c * 4096.0;
      if (c >= 0.0) return int'($floor(c + 0.5));
      return -int'($floor(-c + 0.5));
   endfunction

   function automatic int model(
      input int x_i[8], input bit m, input int k,
      input int in_w, input int out_w
   );
      longint acc;
      longint hi;
      longint lo;
      int     xv;
      acc = 0;
      for (int j = 0; j < 8; j++) begin
         xv  = (x_i[j] <<< (32 - in_w)) >>> (32 - in_w);
         acc += longint'(xv) *
                longint'(m ? qcoef(j, k) : qcoef(k, j));
      end
      acc = (acc + 2048) >>> 12;
      hi  = (longint'(1) <<< (out_w - 1)) - 1;
      lo  = -hi - 1;
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
      return int'(acc);
   endfunction

   task automatic send_block(
      input int xs[8], input bit m,
      input bit flip, input bit push
   );
      exp_t ex;
      if (push) begin
         for (int k = 0; k < 8; k++) begin
            ex.a    = model(xs, m, k, 8, 12);
            ex.w    = model(xs, m, k, 12, 12);
            ex.s    = model(xs, m, k, 8, 8);
            ex.last = (k == 7) ? 1 : 0;
            sb.push_back(ex);
         end
      end
      for (int i = 0; i < 8; i++) begin
         bit hs;
         int guard;
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 12'($urandom);
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = xs[i][11:0];
         mode     = (flip && i > 3) ? ~m : m;
         hs       = 1'b0;
         guard    = 0;
         while (!hs && guard < 200) begin
            @(negedge clk);
            hs = in_ready_a;
            @(posedge clk);
            #1;
            guard++;
         end
         check_eq("in_handshake", int'(hs), 1);
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!in_ready_a && guard < 2000) begin
         in_valid = 1'b1;
         in_data  = 12'($urandom);
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid = 1'b0;
      check_eq("idle_return", int'(in_ready_a), 1);
   endtask

   task automatic rand_x();
      for (int i = 0; i < 8; i++)
         x[i] = int'($urandom_range(0, 4095)) - 2048;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) begin
            out_ready = bp_pat[bp_i];
            bp_i      = (bp_i + 1) % 4;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (clr) begin
         stall     = 1'b0;
         last_seen = 1'b0;
      end else begin
         if (last_seen) begin
            check_eq("ready_after_last",
                     int'(in_ready_a), 1);
            check_eq("idle_after_last", int'(busy_a), 0);
            last_seen = 1'b0;
         end
         if (out_valid_a) begin
            check_eq("in_ready_out", int'(in_ready_a), 0);
            check_eq("busy_out", int'(busy_a), 1);
            if (stall) begin
               check_eq("hold_data",
                        int'($signed(out_data_a)), held_d);
               check_eq("hold_last",
                        int'(out_last_a), held_l);
            end
            if (out_ready) begin
               stall = 1'b0;
               if (sb.size() == 0) begin
                  check_eq("unexpected_out",
                           int'(out_valid_a), 0);
               end else begin
                  e = sb.pop_front();
                  check_eq("y_a",
                           int'($signed(out_data_a)), e.a);
                  check_eq("y_w",
                           int'($signed(out_data_w)), e.w);
                  check_eq("y_s",
                           int'($signed(out_data_s)), e.s);
                  check_eq("last_a", int'(out_last_a), e.last);
                  check_eq("last_s", int'(out_last_s), e.last);
                  check_eq("valid_w", int'(out_valid_w), 1);
                  check_eq("valid_s", int'(out_valid_s), 1);
                  if (e.last != 0) last_seen = 1'b1;
               end
            end else begin
               stall  = 1'b1;
               held_d = int'($signed(out_data_a));
               held_l = int'(out_last_a);
            end
         end else if (stall) begin
            check_eq("valid_held", int'(out_valid_a), 1);
            stall = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clr       = 1'b1;
      mode      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", int'(in_ready_a), 1);
      check_eq("rst_out_valid", int'(out_valid_a), 0);
      check_eq("rst_busy", int'(busy_a), 0);
      check_eq("rst_out_last", int'(out_last_a), 0);
      check_eq("rst_out_data",
               int'($signed(out_data_a)), 0);
      clr = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) x[i] = 100;
      send_block(x, 1'b0, 1'b0, 1'b1);
      lat = 0;
      while (!out_valid_a && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("first_valid_cycle", lat + 1, 65);
      wait_idle();

      x = '{283, 0, 0, 0, 0, 0, 0, 0};
      send_block(x, 1'b1, 1'b0, 1'b1);
      wait_idle();

      for (int i = 0; i < 8; i++) x[i] = 127;
      send_block(x, 1'b0, 1'b0, 1'b1);
      wait_idle();
      for (int i = 0; i < 8; i++) x[i] = -128;
      send_block(x, 1'b0, 1'b0, 1'b1);
      wait_idle();

      bp_en = 1'b1;
      rand_x();
      send_block(x, 1'b0, 1'b0, 1'b1);
      wait_idle();
      rand_x();
      send_block(x, 1'b1, 1'b0, 1'b1);
      wait_idle();
      bp_en = 1'b0;

      rand_x();
      send_block(x, 1'b0, 1'b1, 1'b1);
      wait_idle();

      rand_x();
      send_block(x, 1'b1, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      clr = 1'b1;
      #1;
      check_eq("clr_in_ready", int'(in_ready_a), 1);
      check_eq("clr_out_valid", int'(out_valid_a), 0);
      check_eq("clr_busy", int'(busy_a), 0);
      check_eq("clr_out_last", int'(out_last_a), 0);
      check_eq("clr_out_data",
               int'($signed(out_data_a)), 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (100) @(posedge clk);
      #1;

      rand_x();
      send_block(x, 1'b0, 1'b0, 1'b1);
      wait_idle();
      rand_x();
      send_block(x, 1'b1, 1'b0, 1'b1);
      wait_idle();

      repeat (5) @(posedge clk);
      #1;
      check_eq("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dct8_stream_engine.md
DCT8_STREAM_ENGINE -- requirements
Module: dct8_stream_engine

Interface
REQ-001 Parameters SHALL be: IN_W, default 8, signed input sample width; OUT_W, default 12, signed output coefficient width; COEF_FRAC, default 12, fractional bits of the coefficient ROM.
REQ-002 Ports SHALL be:
- clk  input  1  sole clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-high reset.
- mode  input  1  0 = forward 8-point DCT, 1 = inverse; sampled with the first input beat of a block.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  engine accepts a sample this cycle.
- in_data  input  IN_W  signed sample.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  OUT_W  signed result.
- out_last  output  1  marks the 8th output beat of a block.
- busy  output  1  high in COMPUTE and OUTPUT.

Function
REQ-003 A handshake SHALL occur when valid and ready are both high on a rising edge; data SHALL be ignored otherwise.
REQ-004 States SHALL be LOAD, COMPUTE and OUTPUT.
REQ-005 LOAD SHALL drive in_ready=1 and store samples x[0..7] in arrival order. After the 8th handshake the block SHALL go to COMPUTE.
REQ-006 mode SHALL be latched on the handshake of x[0]. Changes to mode during the rest of the block SHALL have no effect.
REQ-007 Coefficients SHALL be C[k][n] = a(k)*cos((2n+1)k*pi/16), with a(0)=sqrt(1/8) and a(k>0)=1/2.
REQ-008 Each coefficient SHALL be stored as round-half-away-from-zero(C*2^COEF_FRAC) in a signed word of COEF_FRAC+2 bits.
REQ-009 Forward mode SHALL compute y[k] = sum over n of x[n]*C[k][n]. Inverse mode SHALL compute y[n] = sum over k of x[k]*C[k][n], i.e. the transposed matrix.
REQ-010 COMPUTE SHALL use one multiplier and one accumulator, performing one multiply-accumulate per cycle. It SHALL last exactly 64 cycles, producing outputs in index order 0..7.
REQ-011 The accumulator SHALL be IN_W+COEF_FRAC+5 bits, so no intermediate overflow is possible.
REQ-012 Each result SHALL be formed in three steps:
- add 2^(COEF_FRAC-1);
- arithmetic shift right by COEF_FRAC;
- saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-013 Results SHALL be written to an 8-entry output buffer.
REQ-014 out_valid SHALL first rise in the 65th cycle after the 8th input handshake, counting the handshake cycle as cycle 0.
REQ-015 OUTPUT SHALL present y[0..7] in order, one per out handshake, with out_last=1 only on y[7].
REQ-016 While out_ready=0, out_data and out_last SHALL hold stable and out_valid SHALL stay high.
REQ-017 After the y[7] handshake the block SHALL return to LOAD, with in_ready=1 in the next cycle.
REQ-018 in_ready SHALL be 0 throughout COMPUTE and OUTPUT. Blocks SHALL NOT overlap.
REQ-019 in_valid asserted outside LOAD SHALL be ignored and SHALL NOT corrupt state.
REQ-020 busy SHALL equal (state != LOAD).

Reset
REQ-021 Asserting clr SHALL immediately force the following outputs, and SHALL do so at any point, including mid-COMPUTE and mid-OUTPUT:
- state = LOAD, sample count = 0, MAC indices = 0, accumulator = 0;
- in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
REQ-022 Sample and output buffer contents SHALL be don't-care after reset, and no stale result SHALL ever be presented.
REQ-023 After clr deasserts, the first handshake SHALL be treated as x[0] of a new block.

Structure
REQ-024 A shared package dct8_pkg SHALL hold:
- the constant N=8;
- the state enumeration;
- a constant function returning the quantised C[k][n] for a given COEF_FRAC.
REQ-025 A sub-module dct8_coef_rom SHALL supply C[k][n] combinationally from (k,n), with the forward/inverse transposition handled by the index order.
REQ-026 The engine SHALL contain no other sub-modules.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Forward DC, default parameters: all x = 100, mode=0 -> y = 283,0,0,0,0,0,0,0; out_valid rises exactly at cycle 65.
- Inverse impulse: x = 283,0,0,0,0,0,0,0, mode=1 -> all eight y = 100.
- Saturation, OUT_W=8 instance: all x = 127 -> y[0] = 127 (saturated), others 0; all x = -128 -> y[0] = -128.
- Backpressure: out_ready toggled 1,0,0,1 per cycle -> every output value held stable while stalled; out_last only on the 8th beat; in_ready stays 0 until y[7] is accepted.
- Mode latching: mode=0 at x[0] and flipped to 1 after x[3] -> forward result produced.
- Reset mid-COMPUTE, clr pulsed 30 cycles into COMPUTE -> out_valid never asserts for that block; the next 8-sample block yields the correct result.
